input_conditioner: RTL

Front-end stage between the board switches/push-button and the 4-bit register stage. It synchronises and debounces four data switches and one load button. It presents clean switch levels on `out_sw1`..`out_sw4` and produces a single-cycle `enabling` pulse per button press. These outputs connect directly to the register stage's `sw1`..`sw4` and `enabling` inputs.

---
 rtl/input_conditioner.sv | 107 ++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Switch/button front end: two-flop synchronisers, per-channel debounce counters and a
// registered single-cycle load strobe on each accepted button press.
module input_conditioner #(
    parameter int DEBOUNCE_MAX = 50000,
    parameter int CNT_WIDTH    = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic sw1,
    input  logic sw2,
    input  logic sw3,
    input  logic sw4,
    input  logic btn,
    output logic out_sw1,
    output logic out_sw2,
    output logic out_sw3,
    output logic out_sw4,
    output logic enabling
);

    localparam int NCH = 5;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_MAX - 1);

    // Channel order: bit 4 = sw1 ... bit 1 = sw4, bit 0 = btn.
    logic [NCH-1:0] raw_s;
    logic [NCH-1:0] s1_r;
    logic [NCH-1:0] s2_r;
    logic [NCH-1:0] clean_s;
    logic           btn_prev_r;
    logic           enabling_r;

    assign raw_s = {sw1, sw2, sw3, sw4, btn};

    // Two-flop synchroniser for all five raw inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_r <= '0;
            s2_r <= '0;
        end else begin
            s1_r <= raw_s;
            s2_r <= s1_r;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CNT_WIDTH-1:0] cnt_r;
        logic                 clean_r;

        // Clean level flips only after DEBOUNCE_MAX consecutive mismatching cycles.
        always_ff @(posedge clock) begin
            if (reset) begin
                cnt_r   <= '0;
                clean_r <= 1'b0;
            end else if (s2_r[i] == clean_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
                clean_r <= s2_r[i];
                cnt_r   <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_WIDTH'(1);
            end
        end

        assign clean_s[i] = clean_r;
    end

    // Rising-edge detect on the clean button level gives one strobe per press.
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_prev_r <= 1'b0;
            enabling_r <= 1'b0;
        end else begin
            btn_prev_r <= clean_s[0];
            enabling_r <= clean_s[0] & ~btn_prev_r;
        end
    end

    assign out_sw1  = clean_s[4];
    assign out_sw2  = clean_s[3];
    assign out_sw3  = clean_s[2];
    assign out_sw4  = clean_s[1];
    assign enabling = enabling_r;

    input_conditioner_chk u_chk (
        .clock     (clock),
        .reset     (reset),
        .clean_btn (clean_s[0]),
        .enabling  (enabling_r)
    );

endmodule

// Properties of the load strobe: never two cycles long, only while the button is clean-high.
module input_conditioner_chk (
    input logic clock,
    input logic reset,
    input logic clean_btn,
    input logic enabling
);

    a_single_cycle: assert property (@(posedge clock) disable iff (reset)
        enabling |=> !enabling);

    a_btn_high: assert property (@(posedge clock) disable iff (reset)
        enabling |-> clean_btn);

endmodule
